axi_aw_w_arbiter: RTL and testbench
===================================

AXI_AW_W_ARBITER -- requirements
Module: axi_aw_w_arbiter

Interface
REQ-001 SHALL have parameter N_SLAVE_PORT, default 4, number of requesting slave ports (at least 2).
REQ-002 SHALL have parameter AXI_ID_IN, default 4, incoming AW ID width.
REQ-003 SHALL have parameter AXI_ID_OUT, default AXI_ID_IN+$clog2(N_SLAVE_PORT), outgoing AW ID width.
REQ-004 SHALL have parameter AW_PAYLOAD_W, default 64, bundled AW fields excluding ID (addr, len, size, burst, lock, cache, prot, region, qos, user).
REQ-005 SHALL have parameter W_PAYLOAD_W, default 78, bundled W fields excluding last (data, strb, user).
REQ-006 SHALL have parameter FIFO_DEPTH_DW, default 4, write-order FIFO depth (at least 1).
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports slave_aw_valid_i / slave_aw_ready_o, input/output, N_SLAVE_PORT, per-port AW handshake.
REQ-010 SHALL have ports slave_aw_id_i, input, N_SLAVE_PORT x AXI_ID_IN; slave_aw_payload_i, input, N_SLAVE_PORT x AW_PAYLOAD_W.
REQ-011 SHALL have ports master_aw_valid_o / master_aw_ready_i, output/input, 1; master_aw_id_o, output, AXI_ID_OUT; master_aw_payload_o, output, AW_PAYLOAD_W.
REQ-012 SHALL have ports slave_w_valid_i / slave_w_ready_o, input/output, N_SLAVE_PORT; slave_w_last_i, input, N_SLAVE_PORT; slave_w_payload_i, input, N_SLAVE_PORT x W_PAYLOAD_W.
REQ-013 SHALL have ports master_w_valid_o / master_w_ready_i, output/input, 1; master_w_last_o, output, 1; master_w_payload_o, output, W_PAYLOAD_W.
REQ-014 SHALL have port outstanding_o, output, $clog2(FIFO_DEPTH_DW+1), number of AW bursts accepted whose W last beat has not yet been sent.

Function
REQ-015 SHALL arbitrate AW round-robin: the granted port is the first valid port at or after priority pointer ptr (ascending, wrapping); ptr resets to 0.
REQ-016 SHALL, after an AW handshake from port k, set ptr to (k+1) mod N_SLAVE_PORT on the next edge; ptr is unchanged otherwise.
REQ-017 SHALL lock the grant once master_aw_valid_o is high without master_aw_ready_i; the selection holds until the handshake even if higher-priority ports become valid (AXI stability).
REQ-018 SHALL drive master_aw_valid_o = (any slave_aw_valid_i) AND NOT fifo_full, combinationally (zero-cycle latency).
REQ-019 SHALL drive slave_aw_ready_o[g] = master_aw_ready_i AND NOT fifo_full for the granted port g only; all other bits are 0.
REQ-020 SHALL form master_aw_id_o = {g, slave_aw_id_i[g]} (port index in the MSBs) and pass slave_aw_payload_i[g] unchanged.
REQ-021 SHALL push g into the write-order FIFO on every AW handshake.
REQ-022 SHALL route W from port h = FIFO head: master_w_valid_o = NOT fifo_empty AND slave_w_valid_i[h]; slave_w_ready_o[h] = NOT fifo_empty AND master_w_ready_i; other ready bits are 0; payload/last from port h.
REQ-023 SHALL pop the FIFO on a W handshake with master_w_last_o = 1.
REQ-024 SHALL provide no AW-to-W bypass: when the FIFO is empty, W stays blocked; a burst's first W beat is transferable no earlier than the cycle after its AW handshake.
REQ-025 SHALL block push when full even if a pop occurs in the same cycle (no full bypass); simultaneous push and pop when not full leaves the count unchanged.
REQ-026 SHALL keep outstanding_o equal to the FIFO occupancy, registered, range 0..FIFO_DEPTH_DW.
REQ-027 SHALL treat W beats from non-head ports as stalled (ready 0) with no reordering.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear ptr to 0, clear the lock, set FIFO pointers/count to 0 (outstanding_o = 0); outputs then follow REQ-018/REQ-022 (master_w_valid_o = 0, all slave_w_ready_o = 0).
REQ-029 SHALL discard in-flight bursts when reset is asserted mid-operation; no state survives reset.

Verification
REQ-030 SHALL cover: ports 0,1,2,3 all AW-valid continuously, ready = 1 -> grants 0,1,2,3,0 on consecutive cycles, master_aw_id_o MSBs 00,01,10,11.
REQ-031 SHALL cover: port 2 AW valid, master_aw_ready_i = 0 for 3 cycles while port 0 raises valid -> grant stays on port 2 and payload stable until the handshake; then ptr = 3.
REQ-032 SHALL cover: AW from port 1 (len = 3), then AW from port 0 -> W beats from port 0 stall until port 1 has sent 4 beats with last; outstanding_o goes 1,2,1,0.
REQ-033 SHALL cover: FIFO_DEPTH_DW = 4 AWs with no W -> master_aw_valid_o = 0 and slave_aw_ready_o = 0 with a fifth requester; after one W last, the fifth AW is accepted the next cycle, not the same cycle.
REQ-034 SHALL cover: an AW handshake in cycle t with W valid already high -> master_w_valid_o first high in cycle t+1.
REQ-035 SHALL cover: rst_n pulsed low mid-burst with outstanding_o = 2 -> outstanding_o = 0, master_w_valid_o = 0 immediately (asynchronously); the next AW is granted from port 0 priority.

Source files
------------

// File: rtl/axi_aw_w_arbiter.sv
// N-to-1 AXI write-address/write-data arbiter: round-robin AW grant with a
// write-order FIFO that steers W beats from the port whose AW was accepted first.
module axi_aw_w_arbiter #(
    parameter int N_SLAVE_PORT  = 4,
    parameter int AXI_ID_IN     = 4,
    parameter int AXI_ID_OUT    = AXI_ID_IN + $clog2(N_SLAVE_PORT),
    parameter int AW_PAYLOAD_W  = 64,
    parameter int W_PAYLOAD_W   = 78,
    parameter int FIFO_DEPTH_DW = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [N_SLAVE_PORT-1:0]                    slave_aw_valid_i,
    output logic [N_SLAVE_PORT-1:0]                    slave_aw_ready_o,
    input  logic [N_SLAVE_PORT-1:0][AXI_ID_IN-1:0]     slave_aw_id_i,
    input  logic [N_SLAVE_PORT-1:0][AW_PAYLOAD_W-1:0]  slave_aw_payload_i,
    output logic                                       master_aw_valid_o,
    input  logic                                       master_aw_ready_i,
    output logic [AXI_ID_OUT-1:0]                      master_aw_id_o,
    output logic [AW_PAYLOAD_W-1:0]                    master_aw_payload_o,
    input  logic [N_SLAVE_PORT-1:0]                    slave_w_valid_i,
    output logic [N_SLAVE_PORT-1:0]                    slave_w_ready_o,
    input  logic [N_SLAVE_PORT-1:0]                    slave_w_last_i,
    input  logic [N_SLAVE_PORT-1:0][W_PAYLOAD_W-1:0]   slave_w_payload_i,
    output logic                                       master_w_valid_o,
    input  logic                                       master_w_ready_i,
    output logic                                       master_w_last_o,
    output logic [W_PAYLOAD_W-1:0]                     master_w_payload_o,
    output logic [$clog2(FIFO_DEPTH_DW+1)-1:0]         outstanding_o
);

    localparam int IDX_W = $clog2(N_SLAVE_PORT);
    localparam int JW    = IDX_W + 1;
    localparam int PTR_W = (FIFO_DEPTH_DW > 1) ? $clog2(FIFO_DEPTH_DW) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH_DW + 1);

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] fifo_q [FIFO_DEPTH_DW];

    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic [JW-1:0]    j;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] head;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH_DW));
    assign fifo_empty = (cnt_q == '0);

    // First valid port at or after ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = '0;
        for (int i = 0; i < N_SLAVE_PORT; i++) begin
            j = {1'b0, ptr_q} + JW'(i);
            if (j >= JW'(N_SLAVE_PORT)) j = j - JW'(N_SLAVE_PORT);
            if (!rr_found && slave_aw_valid_i[j[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = j[IDX_W-1:0];
            end
        end
    end

    assign grant = (state_q == ARB_LOCKED) ? lock_idx_q : rr_idx;

    assign master_aw_valid_o   = rr_found && !fifo_full;
    assign master_aw_id_o      = AXI_ID_OUT'({grant, slave_aw_id_i[grant]});
    assign master_aw_payload_o = slave_aw_payload_i[grant];

    always_comb begin
        slave_aw_ready_o = '0;
        if (rr_found && !fifo_full) slave_aw_ready_o[grant] = master_aw_ready_i;
    end

    assign push = master_aw_valid_o && master_aw_ready_i;

    // A presented-but-unaccepted request freezes the grant until it completes.
    always_comb begin
        state_d    = ARB_OPEN;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (master_aw_valid_o && !master_aw_ready_i) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = grant;
        end
        if (push) begin
            ptr_d = (grant == IDX_W'(N_SLAVE_PORT - 1)) ? '0 : grant + IDX_W'(1);
        end
    end

    assign head               = fifo_q[rd_ptr_q];
    assign master_w_valid_o   = !fifo_empty && slave_w_valid_i[head];
    assign master_w_last_o    = slave_w_last_i[head];
    assign master_w_payload_o = slave_w_payload_i[head];

    always_comb begin
        slave_w_ready_o = '0;
        if (!fifo_empty) slave_w_ready_o[head] = master_w_ready_i;
    end

    assign pop = master_w_valid_o && master_w_ready_i && master_w_last_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH_DW - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH_DW - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_OPEN;
            lock_idx_q <= '0;
            ptr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Entry contents are only meaningful below cnt_q, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= grant;
    end

    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Directed bench for axi_aw_w_arbiter: a vector table for round-robin grant and
// W steering, then hand sequences for lock, ordering, full, latency and reset.
module tb_axi_aw_w_arbiter;

    logic              clk;
    logic              rst_n;
    logic [3:0]        s_aw_valid;
    logic [3:0]        s_aw_ready;
    logic [3:0][3:0]   s_aw_id;
    logic [3:0][63:0]  s_aw_pl;
    logic              m_aw_valid;
    logic              m_aw_ready;
    logic [5:0]        m_aw_id;
    logic [63:0]       m_aw_pl;
    logic [3:0]        s_w_valid;
    logic [3:0]        s_w_ready;
    logic [3:0]        s_w_last;
    logic [3:0][77:0]  s_w_pl;
    logic              m_w_valid;
    logic              m_w_ready;
    logic              m_w_last;
    logic [77:0]       m_w_pl;
    logic [2:0]        outstanding;

    int checks   = 0;
    int failures = 0;

    axi_aw_w_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .slave_aw_valid_i    (s_aw_valid),
        .slave_aw_ready_o    (s_aw_ready),
        .slave_aw_id_i       (s_aw_id),
        .slave_aw_payload_i  (s_aw_pl),
        .master_aw_valid_o   (m_aw_valid),
        .master_aw_ready_i   (m_aw_ready),
        .master_aw_id_o      (m_aw_id),
        .master_aw_payload_o (m_aw_pl),
        .slave_w_valid_i     (s_w_valid),
        .slave_w_ready_o     (s_w_ready),
        .slave_w_last_i      (s_w_last),
        .slave_w_payload_i   (s_w_pl),
        .master_w_valid_o    (m_w_valid),
        .master_w_ready_i    (m_w_ready),
        .master_w_last_o     (m_w_last),
        .master_w_payload_o  (m_w_pl),
        .outstanding_o       (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    typedef struct {
        logic [3:0] awv;
        logic       awr;
        logic [3:0] wv;
        logic [3:0] wl;
        logic       wr;
        logic       e_mawv;
        logic [3:0] e_awrdy;
        int         e_g;
        logic       e_mwv;
        logic [3:0] e_wrdy;
        logic [2:0] e_out;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [5:0] exp_id(input int g);
        logic [1:0] gi;
        logic [3:0] id;
        gi = 2'(g);
        id = 4'(g + 5);
        return {gi, id};
    endfunction

    function automatic logic [63:0] exp_aw_pl(input int g);
        return 64'hA5A5_0000_0000_0000 + 64'(g * 17);
    endfunction

    function automatic logic [77:0] exp_w_pl(input int g);
        return 78'h2_0000_0000_0000_0000 + 78'(g * 33);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] awv, input logic awr, input logic [3:0] wv,
                         input logic [3:0] wl, input logic wr);
        s_aw_valid = awv;
        m_aw_ready = awr;
        s_w_valid  = wv;
        s_w_last   = wl;
        m_w_ready  = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            s_aw_id[k] = 4'(k + 5);
            s_aw_pl[k] = exp_aw_pl(k);
            s_w_pl[k]  = exp_w_pl(k);
        end

        //           awv      awr   wv       wl       wr    mawv  awrdy    g  mwv   wrdy     out
        tbl[0] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 0, 1'b0, 4'b0000, 3'd0};
        tbl[1] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 1, 1'b1, 4'b0001, 3'd1};
        tbl[2] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2, 1'b1, 4'b0010, 3'd1};
        tbl[3] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 3, 1'b1, 4'b0100, 3'd1};
        tbl[4] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 0, 1'b1, 4'b1000, 3'd1};
        tbl[5] = '{4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 0, 1'b1, 4'b0001, 3'd1};
        tbl[6] = '{4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 0, 1'b0, 4'b0000, 3'd0};

        // Reset state, with W traffic offered to show it stays blocked.
        rst_n = 1'b0;
        drive(4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b1);
        #2;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_m_w_valid", m_w_valid, 0);
        chk("rst_w_ready", s_w_ready, 0);
        do_reset();

        for (int v = 0; v < 7; v++) begin
            drive(tbl[v].awv, tbl[v].awr, tbl[v].wv, tbl[v].wl, tbl[v].wr);
            #1;
            chk($sformatf("tbl%0d_m_aw_valid", v), m_aw_valid, tbl[v].e_mawv);
            chk($sformatf("tbl%0d_aw_ready", v), s_aw_ready, tbl[v].e_awrdy);
            if (tbl[v].e_mawv) begin
                chk($sformatf("tbl%0d_aw_id", v), m_aw_id, exp_id(tbl[v].e_g));
                chk($sformatf("tbl%0d_aw_payload", v), m_aw_pl, exp_aw_pl(tbl[v].e_g));
            end
            chk($sformatf("tbl%0d_m_w_valid", v), m_w_valid, tbl[v].e_mwv);
            chk($sformatf("tbl%0d_w_ready", v), s_w_ready, tbl[v].e_wrdy);
            chk($sformatf("tbl%0d_outstanding", v), outstanding, tbl[v].e_out);
            tick();
        end

        // Grant lock while the master stalls AW.
        do_reset();
        drive(4'b0100, 1'b0, 4'b0, 4'b0, 1'b0);
        #1;
        chk("lock_c0_id", m_aw_id, exp_id(2));
        chk("lock_c0_aw_ready", s_aw_ready, 4'b0000);
        tick();
        for (int c = 1; c < 3; c++) begin
            drive(4'b0101, 1'b0, 4'b0, 4'b0, 1'b0);
            #1;
            chk($sformatf("lock_c%0d_id", c), m_aw_id, exp_id(2));
            chk($sformatf("lock_c%0d_payload", c), m_aw_pl, exp_aw_pl(2));
            tick();
        end
        drive(4'b0101, 1'b1, 4'b0, 4'b0, 1'b0);
        #1;
        chk("lock_hs_aw_ready", s_aw_ready, 4'b0100);
        chk("lock_hs_id", m_aw_id, exp_id(2));
        tick();
        drive(4'b1111, 1'b0, 4'b0, 4'b0, 1'b0);
        #1;
        chk("lock_ptr3_id", m_aw_id, exp_id(3));
        tick();

        // Write ordering: port 1 burst of 4 beats precedes port 0.
        do_reset();
        drive(4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b1);
        #1;
        chk("ord_c0_out", outstanding, 0);
        chk("ord_c0_m_w_valid", m_w_valid, 0);
        tick();
        drive(4'b0001, 1'b1, 4'b0011, 4'b0001, 1'b1);
        #1;
        chk("ord_c1_out", outstanding, 1);
        chk("ord_c1_w_ready", s_w_ready, 4'b0010);
        chk("ord_c1_m_w_valid", m_w_valid, 1);
        tick();
        for (int b = 2; b < 4; b++) begin
            drive(4'b0000, 1'b1, 4'b0011, 4'b0001, 1'b1);
            #1;
            chk($sformatf("ord_beat%0d_out", b), outstanding, 2);
            chk($sformatf("ord_beat%0d_w_ready", b), s_w_ready, 4'b0010);
            chk($sformatf("ord_beat%0d_last", b), m_w_last, 0);
            tick();
        end
        drive(4'b0000, 1'b1, 4'b0011, 4'b0011, 1'b1);
        #1;
        chk("ord_beat4_last", m_w_last, 1);
        chk("ord_beat4_out", outstanding, 2);
        tick();
        drive(4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1);
        #1;
        chk("ord_c5_out", outstanding, 1);
        chk("ord_c5_w_ready", s_w_ready, 4'b0001);
        chk("ord_c5_payload", m_w_pl, exp_w_pl(0));
        tick();
        drive(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        #1;
        chk("ord_c6_out", outstanding, 0);
        chk("ord_c6_m_w_valid", m_w_valid, 0);
        tick();

        // FIFO full: no AW bypass of a same-cycle pop.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
            tick();
        end
        drive(4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1);
        #1;
        chk("full_out", outstanding, 4);
        chk("full_m_aw_valid", m_aw_valid, 0);
        chk("full_aw_ready", s_aw_ready, 4'b0000);
        chk("full_pop_m_w_valid", m_w_valid, 1);
        tick();
        drive(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1);
        #1;
        chk("full_next_out", outstanding, 3);
        chk("full_next_m_aw_valid", m_aw_valid, 1);
        chk("full_next_aw_ready", s_aw_ready, 4'b0001);
        chk("full_next_id", m_aw_id, exp_id(0));
        tick();
        drive(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        #1;
        chk("full_refill_out", outstanding, 4);

        // W waits one cycle after its AW handshake.
        do_reset();
        drive(4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1);
        #1;
        chk("lat_t_m_w_valid", m_w_valid, 0);
        chk("lat_t_w_ready", s_w_ready, 4'b0000);
        chk("lat_t_aw_ready", s_aw_ready, 4'b0100);
        tick();
        drive(4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1);
        #1;
        chk("lat_t1_m_w_valid", m_w_valid, 1);
        chk("lat_t1_payload", m_w_pl, exp_w_pl(2));
        chk("lat_t1_w_ready", s_w_ready, 4'b0100);
        tick();

        // Asynchronous reset mid-burst with two bursts outstanding and a lock held.
        do_reset();
        drive(4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b1000, 1'b0, 4'b0010, 4'b0000, 1'b1);
        #1;
        chk("arst_pre_out", outstanding, 2);
        chk("arst_pre_m_w_valid", m_w_valid, 1);
        tick();
        drive(4'b1000, 1'b0, 4'b0010, 4'b0000, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out", outstanding, 0);
        chk("arst_m_w_valid", m_w_valid, 0);
        chk("arst_w_ready", s_w_ready, 4'b0000);
        #1;
        rst_n = 1'b1;
        drive(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        #1;
        chk("arst_next_id", m_aw_id, exp_id(0));
        chk("arst_next_aw_ready", s_aw_ready, 4'b0001);
        tick();
        #1;
        chk("arst_next_out", outstanding, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
